// File: rtl/dds_channel_scheduler.sv
// Round-robin NCO channel issue into one shared dds core, with channel-tagged samples.
// Define DDS_SCHED_ERR_EN to build the dds-valid vs tag-valid check and sticky err.
module dds_channel_scheduler #(
    parameter int  NUM_CH      = 4,
    parameter int  PHASE_DW    = 16,
    parameter int  OUT_DW      = 16,
    parameter int  DDS_LATENCY = 4,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PHASE_DW-1:0] cfg_ftw,
    input  logic [PHASE_DW-1:0] cfg_poff,
    input  logic                cfg_clr,
    input  logic                cfg_commit,
    output logic [PHASE_DW-1:0] m_axis_dds_phase_tdata,
    output logic                m_axis_dds_phase_tvalid,
    input  logic [OUT_DW-1:0]   s_axis_dds_out_tdata,
    input  logic                s_axis_dds_out_tvalid,
    output logic [OUT_DW-1:0]   m_axis_out_tdata,
    output logic [CH_W-1:0]     m_axis_out_tuser,
    output logic                m_axis_out_tvalid,
    output logic                err
);
    localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

    typedef logic [PHASE_DW-1:0] ph_t;
    typedef struct packed {
        logic            vld;
        logic [CH_W-1:0] ch;
    } tag_t;

    ph_t               acc_q   [NUM_CH];
    ph_t               acc_d   [NUM_CH];
    ph_t               ftw_q   [NUM_CH];
    ph_t               ftw_d   [NUM_CH];
    ph_t               poff_q  [NUM_CH];
    ph_t               poff_d  [NUM_CH];
    ph_t               sftw_q  [NUM_CH];
    ph_t               sftw_d  [NUM_CH];
    ph_t               spoff_q [NUM_CH];
    ph_t               spoff_d [NUM_CH];
    logic [NUM_CH-1:0] sclr_q, sclr_d;
    logic [CH_W-1:0]   slot_q, slot_d;
    logic              pend_q, pend_d;
    logic              rdy_q;
    logic              beat, ch_ok, req, cpoint, do_commit;

    ph_t               ph_data_q;
    logic              ph_vld_q;
    logic [CH_W-1:0]   iss_ch_q;

    tag_t              tag_q [DDS_LATENCY];
    logic [OUT_DW-1:0] out_data_q;
    logic [CH_W-1:0]   out_user_q;
    logic              out_vld_q;

    assign cfg_ready = rdy_q & ~pend_q;

    always_comb begin
        beat      = cfg_valid & cfg_ready;
        ch_ok     = int'(cfg_ch) < NUM_CH;
        req       = beat & ch_ok & cfg_commit;
        cpoint    = enable ? (slot_q == LAST) : (slot_q == '0);
        do_commit = cpoint & (pend_q | req);
        sftw_d    = sftw_q;
        spoff_d   = spoff_q;
        sclr_d    = sclr_q;
        ftw_d     = ftw_q;
        poff_d    = poff_q;
        acc_d     = acc_q;
        pend_d    = pend_q | req;
        slot_d    = slot_q;
        if (beat && ch_ok) begin
            sftw_d[cfg_ch]  = cfg_ftw;
            spoff_d[cfg_ch] = cfg_poff;
            sclr_d[cfg_ch]  = cfg_clr;
        end
        if (enable) begin
            acc_d[slot_q] = acc_q[slot_q] + ftw_q[slot_q];
            slot_d        = (slot_q == LAST) ? '0 : slot_q + CH_W'(1);
        end
        // Shadow already holds any same-cycle beat, so it joins this commit.
        if (do_commit) begin
            ftw_d  = sftw_d;
            poff_d = spoff_d;
            for (int k = 0; k < NUM_CH; k++) begin
                if (sclr_d[k]) acc_d[k] = '0;
            end
            sclr_d = '0;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]   <= '0;
                ftw_q[k]   <= '0;
                poff_q[k]  <= '0;
                sftw_q[k]  <= '0;
                spoff_q[k] <= '0;
            end
            sclr_q    <= '0;
            slot_q    <= '0;
            pend_q    <= 1'b0;
            rdy_q     <= 1'b0;
            ph_data_q <= '0;
            ph_vld_q  <= 1'b0;
            iss_ch_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            ftw_q    <= ftw_d;
            poff_q   <= poff_d;
            sftw_q   <= sftw_d;
            spoff_q  <= spoff_d;
            sclr_q   <= sclr_d;
            slot_q   <= slot_d;
            pend_q   <= pend_d;
            rdy_q    <= 1'b1;
            ph_vld_q <= enable;
            if (enable) begin
                ph_data_q <= acc_q[slot_q] + poff_q[slot_q];
                iss_ch_q  <= slot_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DDS_LATENCY; i++) tag_q[i] <= '0;
            out_data_q <= '0;
            out_user_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            tag_q[0] <= '{vld: ph_vld_q, ch: iss_ch_q};
            for (int i = 1; i < DDS_LATENCY; i++) tag_q[i] <= tag_q[i-1];
            out_data_q <= s_axis_dds_out_tdata;
            out_user_q <= tag_q[DDS_LATENCY-1].ch;
            out_vld_q  <= s_axis_dds_out_tvalid;
        end
    end

    assign m_axis_dds_phase_tdata  = ph_data_q;
    assign m_axis_dds_phase_tvalid = ph_vld_q;
    assign m_axis_out_tdata        = out_data_q;
    assign m_axis_out_tuser        = out_user_q;
    assign m_axis_out_tvalid       = out_vld_q;

`ifdef DDS_SCHED_ERR_EN
    logic [DDS_LATENCY-1:0] live_q;
    logic                   err_q;

    // live_q masks the compare until tags issued after reset reach the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q <= '0;
            err_q  <= 1'b0;
        end else begin
            live_q <= (live_q << 1) | DDS_LATENCY'(1);
            if (live_q[DDS_LATENCY-1] &&
                (s_axis_dds_out_tvalid != tag_q[DDS_LATENCY-1].vld))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Directed bench for dds_channel_scheduler with a 4-stage behavioural dds model.
module tb_dds_channel_scheduler;
    localparam int L = 4;

`ifdef DDS_SCHED_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, enable;
    logic        cfg_valid, cfg_ready, cfg_clr, cfg_commit;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_ftw, cfg_poff;
    logic [15:0] ph_data;
    logic        ph_vld;
    logic [15:0] dds_data;
    logic        dds_vld;
    logic [15:0] out_data;
    logic [1:0]  out_user;
    logic        out_vld;
    logic        err;
    logic        skew;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_channel_scheduler #(
        .NUM_CH(4), .PHASE_DW(16), .OUT_DW(16), .DDS_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_ftw(cfg_ftw), .cfg_poff(cfg_poff), .cfg_clr(cfg_clr),
        .cfg_commit(cfg_commit),
        .m_axis_dds_phase_tdata(ph_data), .m_axis_dds_phase_tvalid(ph_vld),
        .s_axis_dds_out_tdata(dds_data), .s_axis_dds_out_tvalid(dds_vld),
        .m_axis_out_tdata(out_data), .m_axis_out_tuser(out_user),
        .m_axis_out_tvalid(out_vld), .err(err)
    );

    // Coarse sine LUT: 0, +peak, 0, -peak per quadrant.
    function automatic logic [15:0] lut(input logic [15:0] ph);
        case (ph[15:14])
            2'd1:    lut = 16'h7FFF;
            2'd3:    lut = 16'h8001;
            default: lut = 16'h0000;
        endcase
    endfunction

    logic        dv [L];
    logic [15:0] dd [L];
    logic        xv;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) begin
                dv[i] <= 1'b0;
                dd[i] <= 16'h0;
            end
            xv <= 1'b0;
        end else begin
            dv[0] <= ph_vld;
            dd[0] <= lut(ph_data);
            for (int i = 1; i < L; i++) begin
                dv[i] <= dv[i-1];
                dd[i] <= dd[i-1];
            end
            xv <= dv[L-1];
        end
    end

    assign dds_vld  = skew ? xv : dv[L-1];
    assign dds_data = dd[L-1];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] ftw,
                       input logic [15:0] poff, input logic clr,
                       input logic commit);
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_ftw    = ftw;
        cfg_poff   = poff;
        cfg_clr    = clr;
        cfg_commit = commit;
        step;
        cfg_valid  = 1'b0;
        cfg_clr    = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // ch0 steps 0x4000 per frame, ch2 sits at 0x4000, ch1/ch3 stay at 0.
    function automatic logic [15:0] exp_ph(input int k);
        case (k % 4)
            0:       exp_ph = 16'((k / 4) * 'h4000);
            2:       exp_ph = 16'h4000;
            default: exp_ph = 16'h0000;
        endcase
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; skew = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_ftw = '0; cfg_poff = '0;
        cfg_clr = 1'b0; cfg_commit = 1'b0;
        step;
        step;
        check("rst_ready",  32'(cfg_ready), 0);
        check("rst_ph_vld", 32'(ph_vld), 0);
        check("rst_ph",     32'(ph_data), 0);
        check("rst_out_v",  32'(out_vld), 0);
        check("rst_out_d",  32'(out_data), 0);
        check("rst_tuser",  32'(out_user), 0);
        check("rst_err",    32'(err), 0);
        reset = 1'b0;
        step;
        check("ready_rel",  32'(cfg_ready), 1);

        cfg(2'd2, 16'h0000, 16'h4000, 1'b0, 1'b0);
        cfg(2'd0, 16'h4000, 16'h0000, 1'b0, 1'b1);
        check("ready_cmt0", 32'(cfg_ready), 1);

        enable = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            step;
            check("ph_vld", 32'(ph_vld), 1);
            check("ph",     32'(ph_data), 32'(exp_ph(n - 1)));
            if (n >= 6) begin
                check("out_v",  32'(out_vld), 1);
                check("tuser",  32'(out_user), 32'((n - 6) % 4));
                check("out_d",  32'(out_data), 32'(lut(exp_ph(n - 6))));
            end
        end

        cfg(2'd1, 16'h1000, 16'h0000, 1'b0, 1'b0);
        check("mid_ph0",    32'(ph_data), 'h8000);
        cfg(2'd0, 16'h2000, 16'h0000, 1'b0, 1'b1);
        check("pend_rdy1",  32'(cfg_ready), 0);
        step;
        check("pend_rdy2",  32'(cfg_ready), 0);
        step;
        check("cmt_rdy",    32'(cfg_ready), 1);
        step;
        check("old_ftw0",   32'(ph_data), 'hC000);
        step;
        check("old_ftw1",   32'(ph_data), 'h0000);
        step;
        step;
        step;
        check("new_ftw0",   32'(ph_data), 'hE000);
        step;
        check("new_ftw1",   32'(ph_data), 'h1000);

        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step;
            check("dis_vld", 32'(ph_vld), 0);
        end
        enable = 1'b1;
        step;
        check("res_vld",    32'(ph_vld), 1);
        check("res_ph2",    32'(ph_data), 'h4000);
        check("gap_out0",   32'(out_vld), 0);
        step;
        check("res_ph3",    32'(ph_data), 'h0000);
        step;
        check("res_ph0",    32'(ph_data), 'h0000);
        step;
        check("res_ph1",    32'(ph_data), 'h2000);
        step;
        check("gap_out4",   32'(out_vld), 0);
        step;
        check("res_out_v",  32'(out_vld), 1);
        check("res_tuser",  32'(out_user), 2);
        check("res_out_d",  32'(out_data), 'h7FFF);

        enable = 1'b0;
        cfg(2'd1, 16'h1000, 16'h0000, 1'b1, 1'b1);
        check("clr_rdy",    32'(cfg_ready), 1);
        enable = 1'b1;
        step;
        step;
        check("clr_ph1",    32'(ph_data), 'h0000);
        repeat (4) step;
        check("clr_ph1b",   32'(ph_data), 'h1000);
        check("err_clean",  32'(err), 0);

        skew = 1'b1;
        enable = 1'b0;
        step;
        enable = 1'b1;
        repeat (12) step;
        check("err_set",    32'(err), 32'(EXP_ERR));
        enable = 1'b0;
        skew = 1'b0;
        repeat (10) step;
        check("err_sticky", 32'(err), 32'(EXP_ERR));

        reset = 1'b1;
        step;
        step;
        check("rst2_err",   32'(err), 0);
        check("rst2_out_v", 32'(out_vld), 0);
        check("rst2_rdy",   32'(cfg_ready), 0);
        reset = 1'b0;
        step;
        check("rel2_rdy",   32'(cfg_ready), 1);
        enable = 1'b1;
        step;
        check("rel2_ph",    32'(ph_data), 0);
        repeat (8) step;
        check("rel2_err",   32'(err), 0);
        check("rel2_out_v", 32'(out_vld), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
